// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the pipelined MIPS core.
//   alu_op_t   - ALU function codes (3 bits)
//   ctrl_t     - decoded control bundle carried down the pipe
//   fwd_sel_t  - forwarding source selector
//   REG_ZERO   - hard-wired zero register specifier
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_ANDN = 3'd4,
    ALU_ORN  = 3'd5,
    ALU_SUB  = 3'd6,
    ALU_SLT  = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic    regwrite;
    logic    memtoreg;
    logic    memwrite;
    logic    alusrc;
    logic    regdst;
    logic    branch;
    alu_op_t alucontrol;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects the operand value for one EX-stage source register.
//   spec_i                  - source register specifier held in EX
//   data_i                  - value read from the register file in decode
//   regwrite_m_i/.../aluout_m_i  - EX/MEM forwarding source
//   regwrite_w_i/.../result_w_i  - MEM/WB forwarding source
//   data_o                  - selected operand
import mips_pkg::*;

module fwd_mux #(
  parameter int REGW = 5,
  parameter int XLEN = 32
) (
  input  logic [REGW-1:0] spec_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            regwrite_m_i,
  input  logic [REGW-1:0] writereg_m_i,
  input  logic [XLEN-1:0] aluout_m_i,
  input  logic            regwrite_w_i,
  input  logic [REGW-1:0] writereg_w_i,
  input  logic [XLEN-1:0] result_w_i,
  output logic [XLEN-1:0] data_o
);

  fwd_sel_t sel;

  // Younger producer (EX/MEM) wins over MEM/WB; $0 is never forwarded.
  always_comb begin
    sel = FWD_NONE;
    if (spec_i != REGW'(REG_ZERO)) begin
      if (regwrite_m_i && (writereg_m_i == spec_i))      sel = FWD_MEM;
      else if (regwrite_w_i && (writereg_w_i == spec_i)) sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_MEM: data_o = aluout_m_i;
      FWD_WB:  data_o = result_w_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-stage forwarding and
// load-use hazard detection.
//   clk, reset                 - clock, synchronous active-high reset
//   valid_d, rd1_d, rd2_d, rs_d, rt_d, rd_d, imm_d, ctrl_d - decode slot
//   stall_e, flush_e           - hold / squash the EX register
//   *_m, *_w                   - EX/MEM and MEM/WB forwarding sources
//   srca_e, srcb_e, alucontrol_e - ALU a, b, f
//   writedata_e, writereg_e, ctrl_e, valid_e - to EX/MEM
//   lwstall                    - load-use hazard, decode/fetch hold
import mips_pkg::*;

module id_ex_stage #(
  parameter int REGW = 5,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic [REGW-1:0] rd_d,
  input  logic [XLEN-1:0] imm_d,
  input  ctrl_t           ctrl_d,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            regwrite_m,
  input  logic [REGW-1:0] writereg_m,
  input  logic [XLEN-1:0] aluout_m,
  input  logic            regwrite_w,
  input  logic [REGW-1:0] writereg_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] srca_e,
  output logic [XLEN-1:0] srcb_e,
  output logic [2:0]      alucontrol_e,
  output logic [XLEN-1:0] writedata_e,
  output logic [REGW-1:0] writereg_e,
  output ctrl_t           ctrl_e,
  output logic            valid_e,
  output logic            lwstall
);

  logic            valid_q, valid_d_nx;
  logic [XLEN-1:0] rd1_q, rd1_nx, rd2_q, rd2_nx, imm_q, imm_nx;
  logic [REGW-1:0] rs_q, rs_nx, rt_q, rt_nx, rd_q, rd_nx;
  ctrl_t           ctrl_q, ctrl_nx;

  // Load in EX whose destination is read by the instruction in ID.
  assign lwstall = ~flush_e & valid_q & ctrl_q.memtoreg &
                   (rt_q != REGW'(REG_ZERO)) & valid_d &
                   ((rt_q == rs_d) | (rt_q == rt_d));

  // Next-state: stall holds, load-use inserts a bubble, else load decode.
  // reset/flush are handled in the flop block as they override the hold.
  always_comb begin
    valid_d_nx = valid_q;
    rd1_nx     = rd1_q;
    rd2_nx     = rd2_q;
    imm_nx     = imm_q;
    rs_nx      = rs_q;
    rt_nx      = rt_q;
    rd_nx      = rd_q;
    ctrl_nx    = ctrl_q;
    if (!stall_e) begin
      if (lwstall) begin
        valid_d_nx = 1'b0;
        rd1_nx     = '0;
        rd2_nx     = '0;
        imm_nx     = '0;
        rs_nx      = '0;
        rt_nx      = '0;
        rd_nx      = '0;
        ctrl_nx    = '0;
      end else begin
        valid_d_nx = valid_d;
        rd1_nx     = rd1_d;
        rd2_nx     = rd2_d;
        imm_nx     = imm_d;
        rs_nx      = rs_d;
        rt_nx      = rt_d;
        rd_nx      = rd_d;
        ctrl_nx    = ctrl_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d_nx;
      rd1_q   <= rd1_nx;
      rd2_q   <= rd2_nx;
      imm_q   <= imm_nx;
      rs_q    <= rs_nx;
      rt_q    <= rt_nx;
      rd_q    <= rd_nx;
      ctrl_q  <= ctrl_nx;
    end
  end

  fwd_mux #(.REGW(REGW), .XLEN(XLEN)) u_fwd_rs (
    .spec_i      (rs_q),
    .data_i      (rd1_q),
    .regwrite_m_i(regwrite_m),
    .writereg_m_i(writereg_m),
    .aluout_m_i  (aluout_m),
    .regwrite_w_i(regwrite_w),
    .writereg_w_i(writereg_w),
    .result_w_i  (result_w),
    .data_o      (srca_e)
  );

  fwd_mux #(.REGW(REGW), .XLEN(XLEN)) u_fwd_rt (
    .spec_i      (rt_q),
    .data_i      (rd2_q),
    .regwrite_m_i(regwrite_m),
    .writereg_m_i(writereg_m),
    .aluout_m_i  (aluout_m),
    .regwrite_w_i(regwrite_w),
    .writereg_w_i(writereg_w),
    .result_w_i  (result_w),
    .data_o      (writedata_e)
  );

  assign srcb_e       = ctrl_q.alusrc ? imm_q : writedata_e;
  assign writereg_e   = ctrl_q.regdst ? rd_q : rt_q;
  assign alucontrol_e = ctrl_q.alucontrol;
  assign ctrl_e       = ctrl_q;
  assign valid_e      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand sequences for hazards,
// flush/stall priority and synchronous reset.
import mips_pkg::*;

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  ctrl_t       ctrl_d;
  logic        stall_e, flush_e;
  logic        regwrite_m, regwrite_w;
  logic [4:0]  writereg_m, writereg_w;
  logic [31:0] aluout_m, result_w;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  writereg_e;
  ctrl_t       ctrl_e;
  logic        valid_e, lwstall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.REGW(5), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .imm_d(imm_d), .ctrl_d(ctrl_d), .stall_e(stall_e), .flush_e(flush_e),
    .regwrite_m(regwrite_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
    .regwrite_w(regwrite_w), .writereg_w(writereg_w), .result_w(result_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e), .ctrl_e(ctrl_e),
    .valid_e(valid_e), .lwstall(lwstall)
  );

  typedef struct {
    logic        vld;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    ctrl_t       ctrl;
    logic        rwm;
    logic [4:0]  wm;
    logic [31:0] am;
    logic        rww;
    logic [4:0]  ww;
    logic [31:0] rw;
    logic [31:0] ea, eb, ewd;
    logic [2:0]  ef;
    logic [4:0]  ewr;
    logic        ev;
  } vec_t;

  function automatic ctrl_t mk(logic rw, logic m2r, logic mw, logic asrc,
                               logic rdst, alu_op_t f);
    ctrl_t c;
    c.regwrite   = rw;
    c.memtoreg   = m2r;
    c.memwrite   = mw;
    c.alusrc     = asrc;
    c.regdst     = rdst;
    c.branch     = 1'b0;
    c.alucontrol = f;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_fwd();
    regwrite_m = 0; writereg_m = 0; aluout_m = 0;
    regwrite_w = 0; writereg_w = 0; result_w = 0;
  endtask

  task automatic drive_d(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [31:0] im,
                         input ctrl_t c);
    valid_d = v; rd1_d = a; rd2_d = b; rs_d = s; rt_d = t; rd_d = d;
    imm_d = im; ctrl_d = c;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".srca"}, srca_e, 0);
    chk({tag, ".srcb"}, srcb_e, 0);
    chk({tag, ".f"}, 32'(alucontrol_e), 0);
    chk({tag, ".wdata"}, writedata_e, 0);
    chk({tag, ".wreg"}, 32'(writereg_e), 0);
    chk({tag, ".ctrl"}, 32'(ctrl_e), 0);
    chk({tag, ".valid"}, 32'(valid_e), 0);
    chk({tag, ".lwstall"}, 32'(lwstall), 0);
  endtask

  vec_t vecs[6];

  initial begin
    // fields: vld rd1 rd2 imm rs rt rd ctrl | rwm wm am rww ww rw | ea eb ewd ef ewr ev
    vecs[0] = '{1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, mk(1,0,0,0,1,ALU_ADD),
                0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
                32'd5, 32'd7, 32'd7, 3'd2, 5'd3, 1};
    vecs[1] = '{1, 32'd1, 32'd7, 32'd0, 5'd8, 5'd2, 5'd3, mk(1,0,0,0,0,ALU_ADD),
                1, 5'd8, 32'h11, 1, 5'd8, 32'h22,
                32'h11, 32'd7, 32'd7, 3'd2, 5'd2, 1};
    vecs[2] = '{1, 32'd1, 32'd7, 32'd0, 5'd8, 5'd2, 5'd3, mk(1,0,0,0,0,ALU_ADD),
                0, 5'd8, 32'h11, 1, 5'd8, 32'h22,
                32'h22, 32'd7, 32'd7, 3'd2, 5'd2, 1};
    vecs[3] = '{1, 32'd0, 32'h33, 32'd0, 5'd0, 5'd0, 5'd3, mk(1,0,0,0,0,ALU_OR),
                1, 5'd0, 32'hFF, 1, 5'd0, 32'hEE,
                32'd0, 32'h33, 32'h33, 3'd1, 5'd0, 1};
    vecs[4] = '{1, 32'h40, 32'h50, 32'd0, 5'd4, 5'd5, 5'd6, mk(1,0,0,0,1,ALU_SUB),
                1, 5'd4, 32'hAA, 1, 5'd5, 32'hBB,
                32'hAA, 32'hBB, 32'hBB, 3'd6, 5'd6, 1};
    vecs[5] = '{1, 32'h9, 32'h1, 32'hFFFFFFFC, 5'd0, 5'd5, 5'd6, mk(1,0,0,1,0,ALU_ADD),
                1, 5'd5, 32'h77, 0, 5'd0, 32'd0,
                32'h9, 32'hFFFFFFFC, 32'h77, 3'd2, 5'd5, 1};

    // Reset state, with live forwarding sources that must not leak through.
    reset = 1; stall_e = 0; flush_e = 0;
    drive_d(1, 32'hDEAD, 32'hBEEF, 5'd1, 5'd2, 5'd3, 32'h4, mk(1,1,0,0,1,ALU_SLT));
    regwrite_m = 1; writereg_m = 0; aluout_m = 32'h1234;
    regwrite_w = 1; writereg_w = 0; result_w = 32'h5678;
    tick(); tick();
    chk_zero("rst");
    reset = 0;
    idle_fwd();

    // Table-driven vectors: apply, clock, check with inputs still applied.
    for (int i = 0; i < 6; i++) begin
      drive_d(vecs[i].vld, vecs[i].rd1, vecs[i].rd2, vecs[i].rs, vecs[i].rt,
              vecs[i].rd, vecs[i].imm, vecs[i].ctrl);
      regwrite_m = vecs[i].rwm; writereg_m = vecs[i].wm; aluout_m = vecs[i].am;
      regwrite_w = vecs[i].rww; writereg_w = vecs[i].ww; result_w = vecs[i].rw;
      tick();
      chk($sformatf("v%0d.srca", i), srca_e, vecs[i].ea);
      chk($sformatf("v%0d.srcb", i), srcb_e, vecs[i].eb);
      chk($sformatf("v%0d.wdata", i), writedata_e, vecs[i].ewd);
      chk($sformatf("v%0d.f", i), 32'(alucontrol_e), 32'(vecs[i].ef));
      chk($sformatf("v%0d.wreg", i), 32'(writereg_e), 32'(vecs[i].ewr));
      chk($sformatf("v%0d.valid", i), 32'(valid_e), 32'(vecs[i].ev));
      chk($sformatf("v%0d.lwstall", i), 32'(lwstall), 0);
    end
    idle_fwd();

    // Load with rt=$0 never triggers a load-use stall.
    drive_d(1, 32'h100, 32'd0, 5'd1, 5'd0, 5'd0, 32'd4, mk(1,1,0,1,0,ALU_ADD));
    tick();
    drive_d(1, 32'd1, 32'd2, 5'd0, 5'd0, 5'd4, 32'd0, mk(1,0,0,0,1,ALU_ADD));
    #1 chk("lw_r0.lwstall", 32'(lwstall), 0);

    // Load-use: lw $9 in EX, dependent in ID.
    drive_d(1, 32'h100, 32'd0, 5'd1, 5'd9, 5'd0, 32'd4, mk(1,1,0,1,0,ALU_ADD));
    tick();
    drive_d(1, 32'h5, 32'h6, 5'd9, 5'd3, 5'd7, 32'd0, mk(1,0,0,0,1,ALU_OR));
    #1 chk("lu_rs.lwstall", 32'(lwstall), 1);
    valid_d = 0;
    #1 chk("lu_invalid.lwstall", 32'(lwstall), 0);
    valid_d = 1; rs_d = 5'd2; rt_d = 5'd9;
    #1 chk("lu_rt.lwstall", 32'(lwstall), 1);
    flush_e = 1;
    #1 chk("lu_flush.lwstall", 32'(lwstall), 0);
    flush_e = 0; rs_d = 5'd9; rt_d = 5'd3;
    // Stall together with lwstall: register holds, hazard persists.
    stall_e = 1;
    tick();
    chk("lu_stall.valid", 32'(valid_e), 1);
    chk("lu_stall.srcb", srcb_e, 32'd4);
    chk("lu_stall.lwstall", 32'(lwstall), 1);
    stall_e = 0;
    tick();
    chk("lu_bubble.valid", 32'(valid_e), 0);
    chk("lu_bubble.ctrl", 32'(ctrl_e), 0);
    chk("lu_bubble.lwstall", 32'(lwstall), 0);
    // Load now in WB position; dependent enters EX and gets forwarded value.
    regwrite_w = 1; writereg_w = 5'd9; result_w = 32'hDEAD;
    tick();
    chk("lu_dep.valid", 32'(valid_e), 1);
    chk("lu_dep.srca", srca_e, 32'hDEAD);
    chk("lu_dep.f", 32'(alucontrol_e), 1);
    idle_fwd();

    // Flush beats stall.
    drive_d(1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'd0, mk(1,0,0,0,1,ALU_ADD));
    tick();
    flush_e = 1; stall_e = 1;
    tick();
    chk("flush_stall.valid", 32'(valid_e), 0);
    chk("flush_stall.srca", srca_e, 0);
    flush_e = 0; stall_e = 0;

    // Stall alone holds for three cycles while decode changes.
    drive_d(1, 32'h12, 32'h34, 5'd1, 5'd2, 5'd3, 32'd0, mk(1,0,0,0,1,ALU_SUB));
    tick();
    stall_e = 1;
    drive_d(0, 32'h99, 32'h88, 5'd4, 5'd5, 5'd6, 32'd1, mk(0,0,1,1,0,ALU_OR));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d.srca", k), srca_e, 32'h12);
      chk($sformatf("stall%0d.srcb", k), srcb_e, 32'h34);
      chk($sformatf("stall%0d.wreg", k), 32'(writereg_e), 3);
      chk($sformatf("stall%0d.valid", k), 32'(valid_e), 1);
    end
    stall_e = 0;

    // Synchronous reset mid-stream: takes effect at the edge, not before.
    drive_d(1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'd0, mk(1,0,0,0,1,ALU_ADD));
    tick();
    reset = 1;
    #1 chk("sreset_pre.valid", 32'(valid_e), 1);
    chk("sreset_pre.srca", srca_e, 32'd5);
    tick();
    chk_zero("sreset");
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
